// File: rtl/mac_wave_sequencer.sv
// mac_wave_sequencer: issues only the non-zero magnitude bit-columns of a weight tile
// to a bit-serial Wave MAC, MSB first, then flushes the MAC psum and pulses done.
module mac_wave_sequencer #(
    parameter int VEC_LENGTH = 16,
    parameter int MAG_WIDTH  = 7
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0]  w_mag,
    input  logic [VEC_LENGTH-1:0]                 w_sign,
    input  logic                                  acc_clear,
    input  logic                                  hold,
    output logic                                  mac_en,
    output logic                                  mac_load_accum,
    output logic [2:0]                            mac_column_idx,
    output logic [VEC_LENGTH-1:0]                 mac_w_bit,
    output logic [VEC_LENGTH-1:0]                 mac_sign,
    output logic                                  prev_zero,
    output logic                                  busy,
    output logic                                  done
);
    localparam logic [2:0] PRIME = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                           state_q, state_d;
    logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0] mag_q, mag_d;
    logic [VEC_LENGTH-1:0]                sign_q, sign_d;
    logic                                 clr_q, clr_d;
    logic                                 first_q, first_d;
    logic [MAG_WIDTH-1:0]                 mask_q, mask_d;
    logic [MAG_WIDTH-1:0]                 in_mask, col_bit, mask_left;
    logic [2:0]                           col;
    logic [VEC_LENGTH-1:0]                col_w;
    logic                                 run, flush, go;

    // Column selection: highest set mask bit is the next column to issue.
    always_comb begin
        in_mask = '0;
        for (int j = 0; j < VEC_LENGTH; j++) in_mask = in_mask | w_mag[j];
        col = '0;
        for (int c = 0; c < MAG_WIDTH; c++) if (mask_q[c]) col = 3'(c);
        col_bit = MAG_WIDTH'(1) << col;
        mask_left = mask_q & ~col_bit;
        for (int j = 0; j < VEC_LENGTH; j++) col_w[j] = mag_q[j][col];
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        clr_d   = clr_q;
        first_d = first_q;
        mask_d  = mask_q;
        case (state_q)
            PRIME: state_d = IDLE;
            IDLE: if (w_valid) begin
                mag_d   = w_mag;
                sign_d  = w_sign;
                clr_d   = acc_clear;
                mask_d  = in_mask;
                first_d = 1'b1;
                state_d = |in_mask ? RUN : FLUSH;
            end
            RUN: if (!hold) begin
                mask_d  = mask_left;
                first_d = 1'b0;
                state_d = |mask_left ? RUN : FLUSH;
            end
            FLUSH: if (!hold) begin
                first_d = 1'b0;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRIME;
            mag_q   <= '0;
            sign_q  <= '0;
            clr_q   <= 1'b0;
            first_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            clr_q   <= clr_d;
            first_q <= first_d;
            mask_q  <= mask_d;
        end
    end

    // Outputs are forced low while reset is held so the reset cycle is quiet.
    assign run            = !reset && state_q == RUN;
    assign flush          = !reset && state_q == FLUSH;
    assign go             = (run || flush) && !hold;
    assign w_ready        = !reset && state_q == IDLE;
    assign mac_en         = (!reset && state_q == PRIME) || go;
    assign mac_load_accum = go && first_q;
    assign mac_column_idx = run ? col : 3'd0;
    assign mac_w_bit      = run ? col_w : '0;
    assign mac_sign       = run ? sign_q : '0;
    assign prev_zero      = (run || flush) && clr_q;
    assign busy           = run || flush;
    assign done           = !reset && state_q == DONE;
endmodule

// File: tb/tb_mac_wave_sequencer.sv
// tb_mac_wave_sequencer: directed checks of column issue order, timing, hold and reset,
// plus a reconstruction of the signed weight sum from the issued columns.
module tb_mac_wave_sequencer;
    localparam int VL = 16;
    localparam int MW = 7;
    localparam int PREV = 100;

    logic clk = 1'b0;
    logic reset, w_valid, w_ready, acc_clear, hold;
    logic [VL-1:0][MW-1:0] w_mag;
    logic [VL-1:0] w_sign;
    logic mac_en, mac_load_accum, prev_zero, busy, done;
    logic [2:0] mac_column_idx;
    logic [VL-1:0] mac_w_bit, mac_sign;

    int n_tests = 0;
    int n_fail = 0;
    int rec = 0;
    int loads = 0;
    logic [VL-1:0][MW-1:0] m;

    always #5 clk = ~clk;

    mac_wave_sequencer #(.VEC_LENGTH(VL), .MAG_WIDTH(MW)) dut (
        .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
        .w_mag(w_mag), .w_sign(w_sign), .acc_clear(acc_clear), .hold(hold),
        .mac_en(mac_en), .mac_load_accum(mac_load_accum), .mac_column_idx(mac_column_idx),
        .mac_w_bit(mac_w_bit), .mac_sign(mac_sign), .prev_zero(prev_zero),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int colv();
        int s = 0;
        for (int j = 0; j < VL; j++) if (mac_w_bit[j]) s += mac_sign[j] ? -1 : 1;
        return s * (1 << mac_column_idx);
    endfunction

    // Accumulate what the MAC would see this cycle, then advance one clock.
    task automatic tick();
        if (mac_en) begin
            if (mac_load_accum) begin
                rec = prev_zero ? 0 : PREV;
                loads++;
            end
            rec += colv();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_tile(input logic [VL-1:0][MW-1:0] mags, input logic [VL-1:0] signs,
                             input logic clr);
        chk("accept_ready", w_ready, 1);
        w_valid = 1'b1;
        w_mag = mags;
        w_sign = signs;
        acc_clear = clr;
        rec = 0;
        loads = 0;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic mixed_tile();
        m = '0;
        m[0] = 7'h41;
        m[5] = 7'h03;
        load_tile(m, 16'h0020, 1'b1);
        chk("mx_c1_idx", mac_column_idx, 6);
        chk("mx_c1_bits", {mac_w_bit[5], mac_w_bit[0]}, 1);
        chk("mx_c1_load", mac_load_accum, 1);
        chk("mx_c1_pz", prev_zero, 1);
        chk("mx_c1_sign", mac_sign, 16'h0020);
        chk("mx_c1_busy", busy, 1);
        tick();
        chk("mx_c2_idx", mac_column_idx, 1);
        chk("mx_c2_bits", {mac_w_bit[5], mac_w_bit[0]}, 2);
        chk("mx_c2_load", mac_load_accum, 0);
        tick();
        chk("mx_c3_idx", mac_column_idx, 0);
        chk("mx_c3_bits", {mac_w_bit[5], mac_w_bit[0]}, 3);
        tick();
        chk("mx_fl_en", mac_en, 1);
        chk("mx_fl_wbit", mac_w_bit, 0);
        chk("mx_fl_idx", mac_column_idx, 0);
        chk("mx_fl_load", mac_load_accum, 0);
        chk("mx_fl_pz", prev_zero, 1);
        chk("mx_fl_done", done, 0);
        tick();
        chk("mx_c5_done", done, 1);
        chk("mx_c5_en", mac_en, 0);
        chk("mx_c5_busy", busy, 0);
        chk("mx_c5_ready", w_ready, 0);
        tick();
        chk("mx_c6_ready", w_ready, 1);
        chk("mx_c6_done", done, 0);
        chk("mx_result", rec, 62);
        chk("mx_loads", loads, 1);
    endtask

    initial begin
        reset = 1'b1;
        w_valid = 1'b0;
        w_mag = '0;
        w_sign = '0;
        acc_clear = 1'b0;
        hold = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_en", mac_en, 0);
        chk("rst_ready", w_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("prime_en", mac_en, 1);
        chk("prime_wbit", mac_w_bit, 0);
        chk("prime_load", mac_load_accum, 0);
        chk("prime_ready", w_ready, 0);
        tick();
        chk("idle_ready", w_ready, 1);
        chk("idle_en", mac_en, 0);
        chk("idle_wbit", mac_w_bit, 0);
        chk("idle_busy", busy, 0);

        mixed_tile();

        load_tile('0, '0, 1'b0);
        chk("z_fl_en", mac_en, 1);
        chk("z_fl_load", mac_load_accum, 1);
        chk("z_fl_pz", prev_zero, 0);
        chk("z_fl_wbit", mac_w_bit, 0);
        chk("z_fl_busy", busy, 1);
        tick();
        chk("z_c2_done", done, 1);
        tick();
        chk("z_result", rec, PREV);

        for (int j = 0; j < VL; j++) m[j] = 7'h7F;
        load_tile(m, '0, 1'b1);
        w_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            chk("full_idx", mac_column_idx, 7 - c);
            chk("full_wbit", mac_w_bit, 16'hFFFF);
            chk("full_ready", w_ready, 0);
            tick();
        end
        chk("full_fl_busy", busy, 1);
        chk("full_fl_ready", w_ready, 0);
        tick();
        chk("full_c9_done", done, 1);
        chk("full_c9_ready", w_ready, 0);
        tick();
        chk("full_c10_ready", w_ready, 1);
        chk("full_result", rec, 2032);
        chk("full_loads", loads, 1);
        tick();
        w_valid = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_idx", mac_column_idx, 6);
        for (int c = 1; c < 9; c++) tick();
        chk("b2b_done", done, 1);
        tick();

        m = '0;
        m[2] = 7'h15;
        load_tile(m, '0, 1'b1);
        chk("h_c1_idx", mac_column_idx, 4);
        chk("h_c1_load", mac_load_accum, 1);
        tick();
        hold = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("h_en", mac_en, 0);
            chk("h_load", mac_load_accum, 0);
            chk("h_idx", mac_column_idx, 2);
            chk("h_wbit", mac_w_bit, 16'h0004);
            chk("h_busy", busy, 1);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("h_c5_en", mac_en, 1);
        chk("h_c5_idx", mac_column_idx, 2);
        chk("h_c5_load", mac_load_accum, 0);
        tick();
        chk("h_c6_idx", mac_column_idx, 0);
        tick();
        chk("h_c7_done", done, 0);
        tick();
        chk("h_c8_done", done, 1);
        chk("h_result", rec, 21);
        chk("h_loads", loads, 1);
        tick();

        for (int j = 0; j < VL; j++) m[j] = 7'h7F;
        load_tile(m, '0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chk("rm_rst_en", mac_en, 0);
        reset = 1'b0;
        #1;
        chk("rm_prime_en", mac_en, 1);
        chk("rm_prime_busy", busy, 0);
        chk("rm_prime_wbit", mac_w_bit, 0);
        chk("rm_prime_done", done, 0);
        tick();
        chk("rm_idle_done", done, 0);
        chk("rm_idle_ready", w_ready, 1);
        mixed_tile();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
